// File: rtl/rv_pkg.sv
// Shared RV32 R-type definitions: ALU control codes, opcode/func fields and the encode table.
package rv_pkg;

    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned ALU_OP_W = 4;
    localparam int unsigned REG_W    = 5;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    localparam logic [6:0] OPCODE_RTYPE = 7'b0110011;
    localparam logic [6:0] F7_BASE      = 7'b0000000;
    localparam logic [6:0] F7_ALT       = 7'b0100000;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    typedef struct packed {
        logic [6:0]       func7;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rs1;
        logic [2:0]       func3;
        logic [REG_W-1:0] rd;
        logic [6:0]       opcode;
    } rtype_t;

    function automatic logic op_is_valid(input logic [ALU_OP_W-1:0] op);
        return op <= ALU_OP_W'(ALU_AND);
    endfunction

    // Codes outside the table fall back to ADD fields; callers drop them anyway.
    function automatic rtype_t encode_rtype(input logic [ALU_OP_W-1:0] op,
                                            input logic [REG_W-1:0]    rd,
                                            input logic [REG_W-1:0]    rs1,
                                            input logic [REG_W-1:0]    rs2);
        rtype_t w;
        w.func7  = F7_BASE;
        w.rs2    = rs2;
        w.rs1    = rs1;
        w.func3  = F3_ADD_SUB;
        w.rd     = rd;
        w.opcode = OPCODE_RTYPE;
        case (alu_op_e'(op))
            ALU_ADD:  w.func3 = F3_ADD_SUB;
            ALU_SUB:  begin w.func7 = F7_ALT; w.func3 = F3_ADD_SUB; end
            ALU_SLL:  w.func3 = F3_SLL;
            ALU_SLT:  w.func3 = F3_SLT;
            ALU_SLTU: w.func3 = F3_SLTU;
            ALU_XOR:  w.func3 = F3_XOR;
            ALU_SRL:  w.func3 = F3_SRL_SRA;
            ALU_SRA:  begin w.func7 = F7_ALT; w.func3 = F3_SRL_SRA; end
            ALU_OR:   w.func3 = F3_OR;
            ALU_AND:  w.func3 = F3_AND;
            default:  w.func3 = F3_ADD_SUB;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/rtype_encoder_sync_fifo.sv
// Synchronous FIFO with registered pointers/occupancy; head entry is visible on rdata.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = rst_n && push && !full;
    assign do_pop  = rst_n && pop && !empty;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/rtype_encoder.sv
// Encodes ALU operations into R-type words, buffers them, and counts emitted/dropped requests.
module rtype_encoder
    import rv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            alu_op,
    input  logic [4:0]            rd,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] instr,
    output logic                  err,
    output logic [15:0]           emit_cnt,
    output logic [7:0]            err_cnt
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic                  full;
    logic                  empty;
    logic [CNT_W-1:0]      count;
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] word;
    logic                  accept;
    logic                  bad_op;
    logic                  push;
    logic                  pop;

    assign in_ready  = !full;
    assign out_valid = !empty;

    assign accept = rst_n && in_valid && in_ready;
    assign bad_op = !op_is_valid(alu_op);
    assign push   = accept && !bad_op;
    assign pop    = rst_n && out_valid && out_ready;
    assign word   = DATA_WIDTH'(encode_rtype(alu_op, rd, rs1, rs2));

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (word),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Stale memory contents are hidden while nothing is buffered.
    assign instr = empty ? '0 : head;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err      <= 1'b0;
            emit_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            err <= accept && bad_op;
            if (pop) emit_cnt <= emit_cnt + 16'd1;
            if (accept && bad_op && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) assert (count <= CNT_W'(DEPTH));
    end

endmodule

// File: tb/tb_rtype_encoder.sv
// Randomized and directed checks of rtype_encoder against a queue-based reference model.
module tb_rtype_encoder;

    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  alu_op = '0;
    logic [4:0]  rd = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] instr;
    logic        err;
    logic [15:0] emit_cnt;
    logic [7:0]  err_cnt;

    int n_checks = 0;
    int n_errors = 0;

    rtype_encoder #(.DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .instr     (instr),
        .err       (err),
        .emit_cnt  (emit_cnt),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference encoding straight from the op table.
    function automatic logic [31:0] ref_encode(input logic [3:0] op, input logic [4:0] d,
                                               input logic [4:0] s1, input logic [4:0] s2);
        logic [9:0] f;
        case (op)
            4'd0: f = 10'b0000000_000;
            4'd1: f = 10'b0100000_000;
            4'd2: f = 10'b0000000_001;
            4'd3: f = 10'b0000000_010;
            4'd4: f = 10'b0000000_011;
            4'd5: f = 10'b0000000_100;
            4'd6: f = 10'b0000000_101;
            4'd7: f = 10'b0100000_101;
            4'd8: f = 10'b0000000_110;
            default: f = 10'b0000000_111;
        endcase
        return {f[9:3], s2, s1, f[2:0], d, 7'b0110011};
    endfunction

    // ALU control decode of a word; 4'hF marks an unrecognised func7/func3 pair.
    function automatic logic [3:0] alu_decode(input logic [31:0] w);
        case ({w[31:25], w[14:12]})
            10'b0000000_000: return 4'd0;
            10'b0100000_000: return 4'd1;
            10'b0000000_001: return 4'd2;
            10'b0000000_010: return 4'd3;
            10'b0000000_011: return 4'd4;
            10'b0000000_100: return 4'd5;
            10'b0000000_101: return 4'd6;
            10'b0100000_101: return 4'd7;
            10'b0000000_110: return 4'd8;
            10'b0000000_111: return 4'd9;
            default:         return 4'hF;
        endcase
    endfunction

    logic [31:0] q[$];
    logic [15:0] m_emit = '0;
    logic [7:0]  m_errc = '0;
    logic        m_err = 1'b0;

    // Cycle model: update on the edge from the inputs held since the previous edge, then compare.
    always @(posedge clk) begin
        int  sz;
        bit  acc;
        bit  pp;
        sz = q.size();
        if (!rst_n) begin
            q.delete();
            m_emit = '0;
            m_errc = '0;
            m_err  = 1'b0;
        end else begin
            acc = in_valid && (sz < DEPTH);
            pp  = (sz > 0) && out_ready;
            if (pp) begin
                void'(q.pop_front());
                m_emit = m_emit + 16'd1;
            end
            m_err = acc && (alu_op > 4'd9);
            if (acc && alu_op <= 4'd9) q.push_back(ref_encode(alu_op, rd, rs1, rs2));
            if (m_err && m_errc != 8'hFF) m_errc = m_errc + 8'd1;
        end
        #2;
        check_eq("out_valid", 32'(out_valid), 32'(q.size() != 0));
        check_eq("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
        check_eq("instr", instr, (q.size() != 0) ? q[0] : 32'h0);
        check_eq("err", 32'(err), 32'(m_err));
        check_eq("emit_cnt", 32'(emit_cnt), 32'(m_emit));
        check_eq("err_cnt", 32'(err_cnt), 32'(m_errc));
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [4:0] d,
                         input logic [4:0] s1, input logic [4:0] s2, input logic ordy);
        in_valid  = v;
        alu_op    = op;
        rd        = d;
        rs1       = s1;
        rs2       = s2;
        out_ready = ordy;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        cycle();
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_instr", instr, 32'h0);

        // ADD x3,x1,x2
        drive(1'b1, 4'd0, 5'd3, 5'd1, 5'd2, 1'b1);
        cycle();
        in_valid = 1'b0;
        check_eq("add_valid", 32'(out_valid), 32'd1);
        check_eq("add_word", instr, 32'h002081B3);
        cycle();
        check_eq("add_emit", 32'(emit_cnt), 32'd1);

        drive(1'b1, 4'd1, 5'd5, 5'd6, 5'd7, 1'b1);
        cycle();
        in_valid = 1'b0;
        check_eq("sub_word", instr, 32'h407302B3);
        cycle();
        drive(1'b1, 4'd7, 5'd1, 5'd2, 5'd3, 1'b1);
        cycle();
        in_valid = 1'b0;
        check_eq("sra_word", instr, 32'h403150B3);
        cycle();

        // Fill with out_ready low, then drain in order
        drive(1'b1, 4'd0, 5'd3, 5'd1, 5'd2, 1'b0);
        cycle();
        drive(1'b1, 4'd9, 5'd4, 5'd5, 5'd6, 1'b0);
        cycle();
        in_valid = 1'b0;
        check_eq("full_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        check_eq("drain_first", instr, 32'h002081B3);
        cycle();
        check_eq("drain_ready_back", 32'(in_ready), 32'd1);
        check_eq("drain_second", instr, ref_encode(4'd9, 5'd4, 5'd5, 5'd6));
        cycle();
        check_eq("drain_empty", 32'(out_valid), 32'd0);

        // Invalid op handling and saturation
        do_reset();
        drive(1'b1, 4'hC, 5'd1, 5'd1, 5'd1, 1'b1);
        cycle();
        in_valid = 1'b0;
        check_eq("bad_err_hi", 32'(err), 32'd1);
        check_eq("bad_no_valid", 32'(out_valid), 32'd0);
        check_eq("bad_errcnt", 32'(err_cnt), 32'd1);
        cycle();
        check_eq("bad_err_lo", 32'(err), 32'd0);
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 4'(10 + (i % 6)), 5'(i), 5'(i), 5'(i), 1'b1);
            cycle();
        end
        in_valid = 1'b0;
        check_eq("errcnt_sat", 32'(err_cnt), 32'd255);
        cycle();

        // Reset with a full buffer
        drive(1'b1, 4'd5, 5'd9, 5'd8, 5'd7, 1'b0);
        cycle();
        cycle();
        check_eq("prefill_full", 32'(in_ready), 32'd0);
        do_reset();
        check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_ready", 32'(in_ready), 32'd1);
        check_eq("mid_rst_instr", instr, 32'h0);
        check_eq("mid_rst_emit", 32'(emit_cnt), 32'd0);
        check_eq("mid_rst_errcnt", 32'(err_cnt), 32'd0);
        drive(1'b1, 4'd0, 5'd3, 5'd1, 5'd2, 1'b1);
        cycle();
        in_valid = 1'b0;
        check_eq("post_rst_add", instr, 32'h002081B3);
        cycle();

        // Every valid op through the ALU control decoder
        for (int op = 0; op < 10; op++) begin
            drive(1'b1, 4'(op), 5'($urandom), 5'($urandom), 5'($urandom), 1'b1);
            cycle();
            in_valid = 1'b0;
            check_eq("dec_alu", 32'(alu_decode(instr)), 32'(op));
            check_eq("dec_regwrite", 32'(instr[6:0] == 7'b0110011), 32'd1);
            cycle();
        end

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            drive(1'($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 4) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9)),
                  5'($urandom), 5'($urandom), 5'($urandom),
                  1'($urandom_range(0, 2) != 0));
            cycle();
        end
        rst_n = 1'b1;
        in_valid = 1'b0;
        cycle();
        cycle();
        #3;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
